// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver: assembles framed serial bits into WIDTH-bit
// words and hands them to a parallel consumer over a valid/ready handshake.
module sipo_rx #(
   parameter int WIDTH     = 4,
   parameter int LSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_in,
   input  logic             s_valid,
   input  logic             s_start,
   output logic [WIDTH-1:0] p_out,
   output logic             p_valid,
   input  logic             p_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun,
   input  logic             clr_ovr
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] p_out_q, p_out_d;
   logic             p_valid_q, p_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;

   logic [WIDTH-1:0] word;
   logic [CW-1:0]    bit_idx;
   logic [CW-1:0]    phys_idx;
   logic             complete;

   // Merge the incoming bit into the word; a start bit begins from an empty word.
   always_comb begin
      word     = (state_q == SHIFT && !s_start) ? shreg_q : '0;
      bit_idx  = s_start ? '0 : cnt_q;
      phys_idx = (LSB_FIRST != 0) ? bit_idx : (LAST_IDX - bit_idx);
      for (int i = 0; i < WIDTH; i++) begin
         if (CW'(i) == phys_idx) word[i] = s_in;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      p_out_d     = p_out_q;
      p_valid_d   = p_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = overrun_q;
      complete    = 1'b0;

      case (state_q)
         IDLE: begin
            if (s_valid && s_start) begin
               shreg_d = word;
               cnt_d   = CW'(1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (s_valid) begin
               if (s_start) begin
                  frame_err_d = 1'b1;
                  shreg_d     = word;
                  cnt_d       = CW'(1);
               end else if (cnt_q == LAST_IDX) begin
                  complete = 1'b1;
                  shreg_d  = '0;
                  cnt_d    = '0;
                  state_d  = IDLE;
               end else begin
                  shreg_d = word;
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A completed word is accepted only if the output slot is free or draining now.
      if (complete) begin
         if (!p_valid_q || p_ready) begin
            p_out_d   = word;
            p_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (p_valid_q && p_ready) begin
         p_valid_d = 1'b0;
      end

      if (clr_ovr && !(complete && p_valid_q && !p_ready)) overrun_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         p_out_q     <= '0;
         p_valid_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         p_out_q     <= p_out_d;
         p_valid_q   <= p_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign p_out     = p_out_q;
   assign p_valid   = p_valid_q;
   assign busy      = (state_q == SHIFT);
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule
